// File: rtl/sw_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sw_pkg
//  Description : Shared types and constants for the Smith-Waterman scorer:
//                FSM state encoding, weight width, default base width and
//                the 2-bit nucleotide encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package sw_pkg;

    localparam int BASE_W_DEF = 2;
    localparam int WEIGHT_W   = 4;

    localparam logic [1:0] BASE_A = 2'd0;
    localparam logic [1:0] BASE_C = 2'd1;
    localparam logic [1:0] BASE_G = 2'd2;
    localparam logic [1:0] BASE_T = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sw_pe.sv
`default_nettype none
// ============================================================================
//  Module      : sw_pe
//  Description : One Smith-Waterman cell. Holds one query base, its own last
//                H (h_up) and the H_left of the previous valid token (diag).
//                Computes H with clamp at 0 and saturation at 2^SCORE_W-1,
//                and forwards the token with its H to the next cell.
//  Revision    : 1.0 - initial release
// ============================================================================
module sw_pe
    import sw_pkg::*;
#(
    parameter int BASE_WIDTH = BASE_W_DEF,
    parameter int SCORE_W    = 12,
    parameter int IDX_W      = 11
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [BASE_WIDTH-1:0] query_base,
    input  logic [WEIGHT_W-1:0]   match_sc,
    input  logic [WEIGHT_W-1:0]   mismatch_pen,
    input  logic [WEIGHT_W-1:0]   gap_pen,
    input  logic                  in_valid,
    input  logic [BASE_WIDTH-1:0] in_base,
    input  logic [IDX_W-1:0]      in_idx,
    input  logic [SCORE_W-1:0]    in_h,
    output logic                  out_valid,
    output logic [BASE_WIDTH-1:0] out_base,
    output logic [IDX_W-1:0]      out_idx,
    output logic [SCORE_W-1:0]    out_h
);

    // Two extra bits: one for sign, one for headroom above the saturation point.
    localparam int SW = SCORE_W + 2;
    localparam logic signed [SW-1:0] SAT = {2'b00, {SCORE_W{1'b1}}};

    logic [BASE_WIDTH-1:0] q;
    logic [SCORE_W-1:0]    h_up;
    logic [SCORE_W-1:0]    diag;
    logic signed [SW-1:0]  match_s, mis_s, gap_s;
    logic signed [SW-1:0]  diag_s, up_s, left_s, best_s;
    logic [SCORE_W-1:0]    h_new;

    // Cell score: best of diagonal, up and left moves, clamped and saturated.
    always_comb begin
        match_s = $signed({{(SW-WEIGHT_W){1'b0}}, match_sc});
        mis_s   = $signed({{(SW-WEIGHT_W){1'b0}}, mismatch_pen});
        gap_s   = $signed({{(SW-WEIGHT_W){1'b0}}, gap_pen});
        diag_s  = $signed({2'b00, diag}) + ((in_base == q) ? match_s : -mis_s);
        up_s    = $signed({2'b00, h_up}) - gap_s;
        left_s  = $signed({2'b00, in_h}) - gap_s;
        best_s  = '0;
        if (diag_s > best_s) best_s = diag_s;
        if (up_s   > best_s) best_s = up_s;
        if (left_s > best_s) best_s = left_s;
        h_new = (best_s > SAT) ? {SCORE_W{1'b1}} : best_s[SCORE_W-1:0];
    end

    // Cell state and forwarded token; only valid tokens advance the recurrence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q         <= '0;
            h_up      <= '0;
            diag      <= '0;
            out_valid <= 1'b0;
            out_base  <= '0;
            out_idx   <= '0;
            out_h     <= '0;
        end else if (clear) begin
            q         <= query_base;
            h_up      <= '0;
            diag      <= '0;
            out_valid <= 1'b0;
            out_base  <= '0;
            out_idx   <= '0;
            out_h     <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_base <= in_base;
                out_idx  <= in_idx;
                out_h    <= h_new;
                h_up     <= h_new;
                diag     <= in_h;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sw_systolic_scorer.sv
`default_nettype none
// ============================================================================
//  Module      : sw_systolic_scorer
//  Description : Streaming Smith-Waterman local-alignment scorer. A linear
//                chain of QUERY_LEN cells holds the latched query; reference
//                bases stream through one per cycle. Reports the best score
//                and its 1-based end coordinates (no traceback).
//  Revision    : 1.0 - initial release
// ============================================================================
module sw_systolic_scorer
    import sw_pkg::*;
#(
    parameter int QUERY_LEN   = 16,
    parameter int BASE_WIDTH  = BASE_W_DEF,
    parameter int SCORE_W     = 12,
    parameter int REF_LEN_MAX = 1024,
    localparam int RW = $clog2(REF_LEN_MAX + 1),
    localparam int QW = $clog2(QUERY_LEN + 1)
)(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [QUERY_LEN*BASE_WIDTH-1:0] query_seq,
    input  logic [WEIGHT_W-1:0]             match_sc,
    input  logic [WEIGHT_W-1:0]             mismatch_pen,
    input  logic [WEIGHT_W-1:0]             gap_pen,
    input  logic                            ref_valid,
    output logic                            ref_ready,
    input  logic [BASE_WIDTH-1:0]           ref_base,
    input  logic                            ref_last,
    output logic                            busy,
    output logic                            done,
    output logic [SCORE_W-1:0]              best_score,
    output logic [RW-1:0]                   best_ref_end,
    output logic [QW-1:0]                   best_query_end,
    output logic                            ref_trunc
);

    state_t                state, state_nx;
    logic                  start_acc, accept, last_accept;
    logic [RW-1:0]         ref_cnt;
    logic [QW-1:0]         drain_cnt;
    logic [WEIGHT_W-1:0]   match_q, mismatch_q, gap_q;
    logic                  tok_valid;
    logic [BASE_WIDTH-1:0] tok_base;
    logic [RW-1:0]         tok_idx;

    // Chain element 0 is the input token; element j+1 is cell j's output.
    logic [QUERY_LEN:0]    ch_valid;
    logic [BASE_WIDTH-1:0] ch_base [QUERY_LEN+1];
    logic [RW-1:0]         ch_idx  [QUERY_LEN+1];
    logic [SCORE_W-1:0]    ch_h    [QUERY_LEN+1];
    logic                  unused_tail;

    logic [SCORE_W-1:0]    cand_score;
    logic [RW-1:0]         cand_idx;
    logic [QW-1:0]         cand_q;
    logic                  cand_better;

    assign start_acc   = start && (state == ST_IDLE);
    assign accept      = ref_valid && ref_ready;
    assign last_accept = accept && (ref_last || (ref_cnt == RW'(REF_LEN_MAX - 1)));

    assign ch_valid[0] = tok_valid;
    assign ch_base[0]  = tok_base;
    assign ch_idx[0]   = tok_idx;
    assign ch_h[0]     = '0;
    assign unused_tail = ^ch_base[QUERY_LEN];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic: run until the last base is accepted, then drain the chain.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start)             state_nx = ST_RUN;
            ST_RUN:   if (last_accept)       state_nx = ST_DRAIN;
            ST_DRAIN: if (drain_cnt == '0)   state_nx = ST_IDLE;
            default:                         state_nx = ST_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        ref_ready = (state == ST_RUN);
        busy      = (state != ST_IDLE);
    end

    // Run control: weights, reference counter, input token, drain timer, done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_q    <= '0;
            mismatch_q <= '0;
            gap_q      <= '0;
            ref_cnt    <= '0;
            drain_cnt  <= '0;
            tok_valid  <= 1'b0;
            tok_base   <= '0;
            tok_idx    <= '0;
            ref_trunc  <= 1'b0;
            done       <= 1'b0;
        end else begin
            done      <= (state == ST_DRAIN) && (drain_cnt == '0);
            tok_valid <= accept;
            if (accept) begin
                tok_base <= ref_base;
                tok_idx  <= ref_cnt + 1'b1;
                ref_cnt  <= ref_cnt + 1'b1;
            end
            // Drain lasts until the final token has left the last cell and
            // been folded into the best-score register.
            if (last_accept) begin
                drain_cnt <= QW'(QUERY_LEN);
                ref_trunc <= !ref_last;
            end else if ((state == ST_DRAIN) && (drain_cnt != '0)) begin
                drain_cnt <= drain_cnt - 1'b1;
            end
            if (start_acc) begin
                match_q    <= match_sc;
                mismatch_q <= mismatch_pen;
                gap_q      <= gap_pen;
                ref_cnt    <= '0;
                ref_trunc  <= 1'b0;
            end
        end
    end

    generate
        for (genvar j = 0; j < QUERY_LEN; j++) begin : g_pe
            sw_pe #(
                .BASE_WIDTH (BASE_WIDTH),
                .SCORE_W    (SCORE_W),
                .IDX_W      (RW)
            ) u_pe (
                .clk          (clk),
                .rst          (rst),
                .clear        (start_acc),
                .query_base   (query_seq[(QUERY_LEN-1-j)*BASE_WIDTH +: BASE_WIDTH]),
                .match_sc     (match_q),
                .mismatch_pen (mismatch_q),
                .gap_pen      (gap_q),
                .in_valid     (ch_valid[j]),
                .in_base      (ch_base[j]),
                .in_idx       (ch_idx[j]),
                .in_h         (ch_h[j]),
                .out_valid    (ch_valid[j+1]),
                .out_base     (ch_base[j+1]),
                .out_idx      (ch_idx[j+1]),
                .out_h        (ch_h[j+1])
            );
        end
    endgenerate

    // Per-cycle reduction: highest score, ties to smallest ref index then
    // smallest query index; then compare against the held best in that order.
    always_comb begin
        cand_score = '0;
        cand_idx   = '0;
        cand_q     = '0;
        for (int j = 0; j < QUERY_LEN; j++) begin
            if (ch_valid[j+1] &&
                ((ch_h[j+1] > cand_score) ||
                 ((ch_h[j+1] == cand_score) && (ch_idx[j+1] < cand_idx)))) begin
                cand_score = ch_h[j+1];
                cand_idx   = ch_idx[j+1];
                cand_q     = QW'(j + 1);
            end
        end
        cand_better = (cand_score > best_score) ||
                      ((cand_score == best_score) &&
                       ((cand_idx < best_ref_end) ||
                        ((cand_idx == best_ref_end) && (cand_q < best_query_end))));
    end

    // Best-result register: cleared by an accepted start, held after done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_score     <= '0;
            best_ref_end   <= '0;
            best_query_end <= '0;
        end else if (start_acc) begin
            best_score     <= '0;
            best_ref_end   <= '0;
            best_query_end <= '0;
        end else if (cand_better) begin
            best_score     <= cand_score;
            best_ref_end   <= cand_idx;
            best_query_end <= cand_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sw_systolic_scorer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_sw_systolic_scorer
//  Description : Self-checking bench for sw_systolic_scorer (QUERY_LEN=4,
//                SCORE_W=4, REF_LEN_MAX=8). Table-driven alignment runs plus
//                hand-written reset-abort and back-to-back sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sw_systolic_scorer;
    import sw_pkg::*;

    localparam int Q   = 4;
    localparam int BW  = 2;
    localparam int SW  = 4;
    localparam int RLM = 8;
    localparam int RW  = 4;
    localparam int QW  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [Q*BW-1:0] query_seq;
    logic [3:0]    match_sc, mismatch_pen, gap_pen;
    logic          ref_valid;
    logic          ref_ready;
    logic [BW-1:0] ref_base;
    logic          ref_last;
    logic          busy;
    logic          done;
    logic [SW-1:0] best_score;
    logic [RW-1:0] best_ref_end;
    logic [QW-1:0] best_query_end;
    logic          ref_trunc;

    int checks   = 0;
    int failures = 0;

    sw_systolic_scorer #(
        .QUERY_LEN   (Q),
        .BASE_WIDTH  (BW),
        .SCORE_W     (SW),
        .REF_LEN_MAX (RLM)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .query_seq      (query_seq),
        .match_sc       (match_sc),
        .mismatch_pen   (mismatch_pen),
        .gap_pen        (gap_pen),
        .ref_valid      (ref_valid),
        .ref_ready      (ref_ready),
        .ref_base       (ref_base),
        .ref_last       (ref_last),
        .busy           (busy),
        .done           (done),
        .best_score     (best_score),
        .best_ref_end   (best_ref_end),
        .best_query_end (best_query_end),
        .ref_trunc      (ref_trunc)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        string q;
        string r;
        int    m, x, g;
        bit    bubble;
        bit    use_last;
        int    exp_acc;
        int    exp_score;
        int    exp_rend;
        int    exp_qend;
        int    exp_trunc;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [1:0] enc(input byte c);
        case (c)
            "A":     enc = BASE_A;
            "C":     enc = BASE_C;
            "G":     enc = BASE_G;
            default: enc = BASE_T;
        endcase
    endfunction

    function automatic vec_t mk(input string name, input string q, input string r,
                                input int m, input int x, input int g,
                                input bit bubble, input bit use_last, input int acc,
                                input int sc, input int re, input int qe, input int tr);
        vec_t v;
        v.name = name; v.q = q; v.r = r;
        v.m = m; v.x = x; v.g = g;
        v.bubble = bubble; v.use_last = use_last; v.exp_acc = acc;
        v.exp_score = sc; v.exp_rend = re; v.exp_qend = qe; v.exp_trunc = tr;
        return v;
    endfunction

    task automatic load_query(input string q, input int m, input int x, input int g);
        for (int j = 0; j < Q; j++) query_seq[(Q-1-j)*BW +: BW] = enc(q[j]);
        match_sc     = 4'(m);
        mismatch_pen = 4'(x);
        gap_pen      = 4'(g);
    endtask

    // Called at a negedge; leaves the bench at a negedge.
    task automatic run_case(input vec_t v, input bit b2b);
        int  idx, acc, since, guard;
        bit  phase, will;
        load_query(v.q, v.m, v.x, v.g);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({v.name, ".busy_start"}, int'(busy), 1);
        check({v.name, ".ready_start"}, int'(ref_ready), 1);
        check({v.name, ".done_start"}, int'(done), 0);
        idx = 0; acc = 0; since = 0; phase = 1'b0; guard = 0;
        while (idx < v.r.len() && guard < 40) begin
            guard++;
            if (v.bubble && phase) begin
                ref_valid = 1'b0;
                ref_last  = 1'b0;
            end else begin
                ref_valid = 1'b1;
                ref_base  = enc(v.r[idx]);
                ref_last  = v.use_last && (idx == v.r.len() - 1);
                idx++;
            end
            phase = !phase;
            will  = ref_valid && ref_ready;
            @(negedge clk);
            if (will) begin
                acc++;
                since = 0;
            end else begin
                since++;
            end
        end
        ref_valid = 1'b0;
        ref_last  = 1'b0;
        check({v.name, ".accepts"}, acc, v.exp_acc);
        check({v.name, ".ready_drain"}, int'(ref_ready), 0);
        guard = 0;
        while (!done && guard < 40) begin
            @(negedge clk);
            since++;
            guard++;
        end
        check({v.name, ".done_seen"}, int'(done), 1);
        check({v.name, ".done_latency"}, since, Q + 1);
        check({v.name, ".busy_done"}, int'(busy), 0);
        check({v.name, ".score"}, int'(best_score), v.exp_score);
        check({v.name, ".ref_end"}, int'(best_ref_end), v.exp_rend);
        check({v.name, ".query_end"}, int'(best_query_end), v.exp_qend);
        check({v.name, ".trunc"}, int'(ref_trunc), v.exp_trunc);
        if (!b2b) begin
            @(negedge clk);
            check({v.name, ".done_pulse"}, int'(done), 0);
            check({v.name, ".score_hold"}, int'(best_score), v.exp_score);
        end
    endtask

    initial begin
        int done_cnt;
        rst = 1'b1; start = 1'b0; ref_valid = 1'b0; ref_last = 1'b0;
        ref_base = '0; query_seq = '0;
        match_sc = '0; mismatch_pen = '0; gap_pen = '0;
        repeat (3) @(negedge clk);
        check("reset.ready", int'(ref_ready), 0);
        check("reset.busy", int'(busy), 0);
        check("reset.done", int'(done), 0);
        check("reset.score", int'(best_score), 0);
        check("reset.ref_end", int'(best_ref_end), 0);
        check("reset.query_end", int'(best_query_end), 0);
        check("reset.trunc", int'(ref_trunc), 0);
        rst = 1'b0;
        @(negedge clk);

        //            name      query   ref           m  x  g  bub last acc sc re qe tr
        vecs[0] = mk("exact",   "ACGT", "ACGT",       2, 1, 2, 0,  1,   4,  8, 4, 4, 0);
        vecs[1] = mk("nomatch", "AAAA", "TTTT",       2, 1, 2, 0,  1,   4,  0, 0, 0, 0);
        vecs[2] = mk("bubbles", "ACGT", "ACGT",       2, 1, 2, 1,  1,   4,  8, 4, 4, 0);
        vecs[3] = mk("tie",     "AAAA", "A",          2, 1, 2, 0,  1,   1,  2, 1, 1, 0);
        vecs[4] = mk("satur",   "AAAA", "AAAA",       5, 1, 2, 0,  1,   4, 15, 3, 3, 0);
        vecs[5] = mk("shift",   "ACGT", "TACG",       2, 1, 2, 0,  1,   4,  6, 4, 3, 0);
        vecs[6] = mk("gap",     "ACGT", "AGT",        2, 3, 1, 0,  1,   3,  5, 3, 4, 0);
        vecs[7] = mk("trunc",   "ACGT", "ACGTACGTAC", 2, 1, 2, 0,  0,   8,  8, 4, 4, 1);

        // The first run hands straight into the second with start in the done cycle.
        for (int i = 0; i < 8; i++) run_case(vecs[i], i == 0);

        // Abort mid-run with an asynchronous reset.
        load_query("ACGT", 2, 1, 2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ref_valid = 1'b1;
            ref_base  = enc(vecs[0].r[k]);
            @(negedge clk);
        end
        ref_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("abort.score_before", int'(best_score), 6);
        #2 rst = 1'b1;
        #1;
        check("abort.busy", int'(busy), 0);
        check("abort.ready", int'(ref_ready), 0);
        check("abort.score", int'(best_score), 0);
        check("abort.ref_end", int'(best_ref_end), 0);
        check("abort.query_end", int'(best_query_end), 0);
        check("abort.trunc", int'(ref_trunc), 0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("abort.no_done", done_cnt, 0);
        run_case(vecs[0], 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
